// File: rtl/sys_bus_bridge.sv
// sys_bus_bridge: CPU-side system bridge between the M stage and data memory,
// NUM_DEV ready-handshaked peripherals and the interrupt-generator write port.
// Decodes the address, raises AdEL/AdES, and stalls the CPU while a device
// access is outstanding.
//
// Optional feature macro: BRIDGE_TIMEOUT_EN. When it is defined, a WAIT that
// lasts TIMEOUT cycles ends with a bus error. When it is undefined, WAIT
// leaves only on dev_ready.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   cpu_*                M-stage request (type/addr/wdata/byteen/exc_in) and
//                        response (rdata/stall/exc_out)
//   dm_*                 data-memory port, zero wait states
//   dev_*                registered device request, one-hot select, flat read
//                        bus, per-device ready and irq
//   ext_interrupt        external interrupt level
//   int_addr/int_byteen  interrupt-generator write port
//   hwint                {zero pad, ext_interrupt, dev_irq}
module sys_bus_bridge #(
    parameter int unsigned NUM_DEV    = 2,
    parameter logic [31:0] DM_TOP     = 32'h2FFF,
    parameter logic [31:0] DEV_BASE   = 32'h7F00,
    parameter logic [31:0] DEV_STRIDE = 32'h10,
    parameter logic [31:0] INT_ADDR   = 32'h7F20,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            cpu_type,
    input  logic [31:0]           cpu_addr,
    input  logic [31:0]           cpu_wdata,
    input  logic [3:0]            cpu_byteen,
    input  logic [4:0]            cpu_exc_in,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_stall,
    output logic [4:0]            cpu_exc_out,
    output logic [31:0]           dm_addr,
    output logic [31:0]           dm_wdata,
    output logic [3:0]            dm_byteen,
    input  logic [31:0]           dm_rdata,
    output logic [29:0]           dev_addr,
    output logic [31:0]           dev_wdata,
    output logic                  dev_we,
    output logic [NUM_DEV-1:0]    dev_sel,
    input  logic [32*NUM_DEV-1:0] dev_rdata,
    input  logic [NUM_DEV-1:0]    dev_ready,
    input  logic [NUM_DEV-1:0]    dev_irq,
    input  logic                  ext_interrupt,
    output logic [31:0]           int_addr,
    output logic [3:0]            int_byteen,
    output logic [5:0]            hwint
);

    localparam logic [5:0] OpLw = 6'h23, OpLh = 6'h21, OpLb = 6'h20;
    localparam logic [5:0] OpSw = 6'h2b, OpSh = 6'h29, OpSb = 6'h28;
    localparam logic [4:0] ExcAdEL = 5'd4, ExcAdES = 5'd5;

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e              state_q;
    logic [1:0]          idx_q;
    logic [31:0]         rdata_q;
    logic                bus_err_q;

    logic                is_load, is_store, is_dm, is_int, dev_hit, hit_count_reg, unmapped;
    logic [1:0]          hit_idx;
    logic [NUM_DEV-1:0]  hit_sel;
    logic                adel, ades, dev_issue, sel_ready;
    logic [31:0]         sel_rdata;

    // ---------------- Address / opcode decode ----------------
    always_comb begin
        dev_hit       = 1'b0;
        hit_idx       = '0;
        hit_sel       = '0;
        hit_count_reg = 1'b0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (cpu_addr >= DEV_BASE + DEV_STRIDE * 32'(i) &&
                cpu_addr <= DEV_BASE + DEV_STRIDE * 32'(i) + 32'd11) begin
                dev_hit       = 1'b1;
                hit_idx       = 2'(i);
                hit_sel       = '0;
                hit_sel[i]    = 1'b1;
                hit_count_reg = (cpu_addr == DEV_BASE + DEV_STRIDE * 32'(i) + 32'd8);
            end
        end
    end

    assign is_load  = (cpu_type == OpLw) || (cpu_type == OpLh) || (cpu_type == OpLb);
    assign is_store = (cpu_type == OpSw) || (cpu_type == OpSh) || (cpu_type == OpSb);
    assign is_dm    = (cpu_addr <= DM_TOP);
    assign is_int   = (cpu_addr >= INT_ADDR) && (cpu_addr <= INT_ADDR + 32'd3);
    assign unmapped = !(is_dm || is_int || dev_hit);

    assign adel = is_load && (((cpu_type == OpLw) && (cpu_addr[1:0] != 2'b00)) ||
                              ((cpu_type == OpLh) && cpu_addr[0]) ||
                              ((cpu_type != OpLw) && dev_hit) ||
                              unmapped);
    // The count register at device offset 8 is read-only for word stores.
    assign ades = is_store && (((cpu_type == OpSw) && (cpu_addr[1:0] != 2'b00)) ||
                               ((cpu_type == OpSh) && cpu_addr[0]) ||
                               ((cpu_type != OpSw) && dev_hit) ||
                               ((cpu_type == OpSw) && dev_hit && hit_count_reg) ||
                               unmapped);

    assign dev_issue = dev_hit && ((is_load && !adel) || (is_store && !ades));

    // Ready and read data of the device currently being waited on.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (idx_q == 2'(i)) begin
                sel_ready = dev_ready[i];
                sel_rdata = dev_rdata[32*i +: 32];
            end
        end
    end

    // ---------------- Device access FSM ----------------
`ifdef BRIDGE_TIMEOUT_EN
    logic [3:0] cnt_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            rdata_q   <= '0;
            bus_err_q <= 1'b0;
            dev_sel   <= '0;
            dev_we    <= 1'b0;
            dev_addr  <= '0;
            dev_wdata <= '0;
`ifdef BRIDGE_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (dev_issue) begin
                        state_q   <= StWait;
                        idx_q     <= hit_idx;
                        dev_sel   <= hit_sel;
                        dev_we    <= is_store;
                        dev_addr  <= cpu_addr[31:2];
                        dev_wdata <= cpu_wdata;
                        rdata_q   <= '0;
                        bus_err_q <= 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
                        cnt_q     <= '0;
`endif
                    end
                end
                StWait: begin
                    // Ready takes priority over an expiring timeout.
                    if (sel_ready) begin
                        rdata_q <= sel_rdata;
                        dev_sel <= '0;
                        state_q <= StDone;
                    end
`ifdef BRIDGE_TIMEOUT_EN
                    else if (cnt_q == 4'(TIMEOUT - 1)) begin
                        bus_err_q <= 1'b1;
                        dev_sel   <= '0;
                        state_q   <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
`endif
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // ---------------- CPU / DM / INT outputs ----------------
    assign dm_addr  = cpu_addr;
    assign dm_wdata = cpu_wdata;
    assign int_addr = cpu_addr;

    always_comb begin
        cpu_stall   = 1'b0;
        cpu_rdata   = '0;
        cpu_exc_out = cpu_exc_in;
        dm_byteen   = '0;
        int_byteen  = '0;
        unique case (state_q)
            StIdle: begin
                cpu_stall = dev_issue;
                if (adel)      cpu_exc_out = ExcAdEL;
                else if (ades) cpu_exc_out = ExcAdES;
                if (is_load && is_dm && !adel)   cpu_rdata  = dm_rdata;
                if (is_store && is_dm && !ades)  dm_byteen  = cpu_byteen;
                if (is_store && is_int && !ades) int_byteen = cpu_byteen;
            end
            StWait: cpu_stall = 1'b1;
            StDone: begin
                cpu_rdata = rdata_q;
                if (bus_err_q) cpu_exc_out = dev_we ? ExcAdES : ExcAdEL;
            end
            default: ;
        endcase
    end

    always_comb begin
        hwint                = '0;
        hwint[NUM_DEV-1:0]   = dev_irq;
        hwint[NUM_DEV]       = ext_interrupt;
    end

endmodule

// File: tb/tb_sys_bus_bridge.sv
// Self-checking bench for sys_bus_bridge: table of zero-wait-state / faulting
// accesses plus hand-written device handshake, timeout and reset sequences.
module tb_sys_bus_bridge;

    localparam logic [5:0] LW = 6'h23, LH = 6'h21, LB = 6'h20;
    localparam logic [5:0] SW = 6'h2b, SH = 6'h29, SB = 6'h28, NOP = 6'h00;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  cpu_type;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, dm_addr, dm_wdata, dm_rdata, int_addr;
    logic [3:0]  cpu_byteen, dm_byteen, int_byteen;
    logic [4:0]  cpu_exc_in, cpu_exc_out;
    logic        cpu_stall, dev_we, ext_interrupt;
    logic [29:0] dev_addr;
    logic [31:0] dev_wdata;
    logic [1:0]  dev_sel, dev_ready, dev_irq;
    logic [63:0] dev_rdata;
    logic [5:0]  hwint;

    int total = 0;
    int passed = 0;
    int commits = 0;
    int n;

    always #5 clk = ~clk;

    sys_bus_bridge dut (
        .clk(clk), .reset(reset),
        .cpu_type(cpu_type), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_byteen(cpu_byteen), .cpu_exc_in(cpu_exc_in),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_exc_out(cpu_exc_out),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_byteen(dm_byteen), .dm_rdata(dm_rdata),
        .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_we(dev_we), .dev_sel(dev_sel),
        .dev_rdata(dev_rdata), .dev_ready(dev_ready), .dev_irq(dev_irq),
        .ext_interrupt(ext_interrupt),
        .int_addr(int_addr), .int_byteen(int_byteen), .hwint(hwint)
    );

    // Device-side view of write commits.
    always @(posedge clk) if (dev_we && |(dev_sel & dev_ready)) commits++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic drive(input logic [5:0] t, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, input logic [4:0] ei);
        cpu_type = t; cpu_addr = a; cpu_wdata = wd; cpu_byteen = be; cpu_exc_in = ei;
    endtask

    typedef struct {
        logic [5:0]  typ;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [4:0]  exc_in;
        logic [31:0] dmr;
        logic [31:0] e_rdata;
        logic [4:0]  e_exc;
        logic [3:0]  e_dm_be;
        logic [3:0]  e_int_be;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vecs.push_back('{LW,  32'h1004, 4'h0, 5'd0, 32'hDEADBEEF, 32'hDEADBEEF, 5'd0, 4'h0, 4'h0});
        vecs.push_back('{LW,  32'h1008, 4'h0, 5'd3, 32'h01234567, 32'h01234567, 5'd3, 4'h0, 4'h0});
        vecs.push_back('{SW,  32'h1000, 4'hF, 5'd0, 32'h0,        32'h0,        5'd0, 4'hF, 4'h0});
        vecs.push_back('{SH,  32'h7F04, 4'h3, 5'd0, 32'h0,        32'h0,        5'd5, 4'h0, 4'h0});
        vecs.push_back('{LB,  32'h7F00, 4'h0, 5'd0, 32'h0,        32'h0,        5'd4, 4'h0, 4'h0});
        vecs.push_back('{SW,  32'h7F08, 4'hF, 5'd0, 32'h0,        32'h0,        5'd5, 4'h0, 4'h0});
        vecs.push_back('{LW,  32'h7F0C, 4'h0, 5'd0, 32'h0,        32'h0,        5'd4, 4'h0, 4'h0});
        vecs.push_back('{LW,  32'h0002, 4'h0, 5'd0, 32'h55AA55AA, 32'h0,        5'd4, 4'h0, 4'h0});
        vecs.push_back('{SW,  32'h7F20, 4'hF, 5'd0, 32'h0,        32'h0,        5'd0, 4'h0, 4'hF});
        vecs.push_back('{LW,  32'h7F20, 4'h0, 5'd0, 32'h12345678, 32'h0,        5'd0, 4'h0, 4'h0});
        vecs.push_back('{SB,  32'h3000, 4'h1, 5'd0, 32'h0,        32'h0,        5'd5, 4'h0, 4'h0});
        vecs.push_back('{LH,  32'h2FFE, 4'h0, 5'd0, 32'hA5A5A5A5, 32'hA5A5A5A5, 5'd0, 4'h0, 4'h0});
        vecs.push_back('{NOP, 32'h7F00, 4'hF, 5'd7, 32'h0,        32'h0,        5'd7, 4'h0, 4'h0});
        vecs.push_back('{SH,  32'h0003, 4'h3, 5'd0, 32'h0,        32'h0,        5'd5, 4'h0, 4'h0});
        vecs.push_back('{SW,  32'h7F24, 4'hF, 5'd0, 32'h0,        32'h0,        5'd5, 4'h0, 4'h0});
        vecs.push_back('{SW,  32'h7F1C, 4'hF, 5'd0, 32'h0,        32'h0,        5'd5, 4'h0, 4'h0});
        vecs.push_back('{LH,  32'h7F12, 4'h0, 5'd0, 32'h0,        32'h0,        5'd4, 4'h0, 4'h0});
        vecs.push_back('{SB,  32'h2FFF, 4'h8, 5'd0, 32'h0,        32'h0,        5'd0, 4'h8, 4'h0});

        reset = 1'b1; drive(NOP, 32'h0, 32'h0, 4'h0, 5'd0);
        dm_rdata = '0; dev_ready = '0; dev_irq = '0; ext_interrupt = 1'b0;
        dev_rdata = {32'h11111111, 32'hCAFEF00D};
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset dev_sel", 32'(dev_sel), 32'h0);
        chk("reset dev_we", 32'(dev_we), 32'h0);
        chk("reset dev_addr", 32'(dev_addr), 32'h0);
        chk("reset dev_wdata", dev_wdata, 32'h0);
        chk("reset stall", 32'(cpu_stall), 32'h0);

        // Zero-wait-state and faulting accesses.
        foreach (vecs[k]) begin
            @(posedge clk); #1;
            drive(vecs[k].typ, vecs[k].addr, 32'hF00D0000 + 32'(k), vecs[k].be, vecs[k].exc_in);
            dm_rdata = vecs[k].dmr;
            @(negedge clk);
            chk($sformatf("vec%0d rdata", k), cpu_rdata, vecs[k].e_rdata);
            chk($sformatf("vec%0d exc", k), 32'(cpu_exc_out), 32'(vecs[k].e_exc));
            chk($sformatf("vec%0d dm_byteen", k), 32'(dm_byteen), 32'(vecs[k].e_dm_be));
            chk($sformatf("vec%0d int_byteen", k), 32'(int_byteen), 32'(vecs[k].e_int_be));
            chk($sformatf("vec%0d stall", k), 32'(cpu_stall), 32'h0);
            chk($sformatf("vec%0d dev_sel", k), 32'(dev_sel), 32'h0);
            chk($sformatf("vec%0d dm_addr", k), dm_addr, vecs[k].addr);
        end

        // SW 0x7F14 -> device 1, ready in the third WAIT cycle: 4 stall cycles.
        @(posedge clk); #1 drive(SW, 32'h7F14, 32'h5, 4'hF, 5'd0);
        dev_irq = 2'b01; ext_interrupt = 1'b1;
        @(negedge clk);
        chk("sw issue stall", 32'(cpu_stall), 32'h1);
        chk("sw issue dev_sel", 32'(dev_sel), 32'h0);
        @(posedge clk); #1 dev_ready = 2'b01;  // unselected device, ignored
        @(negedge clk);
        chk("sw wait1 stall", 32'(cpu_stall), 32'h1);
        chk("sw dev_sel", 32'(dev_sel), 32'h2);
        chk("sw dev_addr", 32'(dev_addr), 32'h1FC5);
        chk("sw dev_wdata", dev_wdata, 32'h5);
        chk("sw dev_we", 32'(dev_we), 32'h1);
        chk("hwint in stall", 32'(hwint), 32'h05);
        @(posedge clk); #1 dev_ready = 2'b00;
        @(negedge clk);
        chk("sw wait2 stall", 32'(cpu_stall), 32'h1);
        @(posedge clk); #1 dev_ready = 2'b10;
        @(negedge clk);
        chk("sw wait3 stall", 32'(cpu_stall), 32'h1);
        @(posedge clk); #1 dev_ready = 2'b00;
        @(negedge clk);
        chk("sw done stall", 32'(cpu_stall), 32'h0);
        chk("sw done dev_sel", 32'(dev_sel), 32'h0);
        chk("sw done exc", 32'(cpu_exc_out), 32'h0);
        chk("sw commits", 32'(commits), 32'h1);
        @(posedge clk); #1 drive(NOP, 32'h0, 32'h0, 4'h0, 5'd0);
        dev_irq = 2'b10; ext_interrupt = 1'b0;
        @(negedge clk);
        chk("idle after done", 32'(cpu_stall), 32'h0);
        chk("hwint 2", 32'(hwint), 32'h02);

        // LW 0x7F08 (count register is readable), ready in first WAIT: 2 stalls.
        @(posedge clk); #1 drive(LW, 32'h7F08, 32'h0, 4'h0, 5'd2);
        @(negedge clk);
        chk("lw issue stall", 32'(cpu_stall), 32'h1);
        chk("lw issue exc", 32'(cpu_exc_out), 32'h2);
        @(posedge clk); #1 dev_ready = 2'b01;
        @(negedge clk);
        chk("lw wait stall", 32'(cpu_stall), 32'h1);
        chk("lw dev_sel", 32'(dev_sel), 32'h1);
        chk("lw dev_we", 32'(dev_we), 32'h0);
        @(posedge clk); #1 dev_ready = 2'b00;
        @(negedge clk);
        chk("lw done stall", 32'(cpu_stall), 32'h0);
        chk("lw done rdata", cpu_rdata, 32'hCAFEF00D);
        chk("lw done exc", 32'(cpu_exc_out), 32'h2);
        @(posedge clk); #1 drive(NOP, 32'h0, 32'h0, 4'h0, 5'd0);

        // LW 0x7F00 without ready.
        @(posedge clk); #1 drive(LW, 32'h7F00, 32'h0, 4'h0, 5'd0);
        @(negedge clk);
        n = 0;
        while (cpu_stall === 1'b1 && n < 40) begin
            n++;
`ifndef BRIDGE_TIMEOUT_EN
            if (n == 20) dev_ready = 2'b01;
`endif
            @(negedge clk);
        end
`ifdef BRIDGE_TIMEOUT_EN
        chk("timeout stall cycles", 32'(n), 32'd16);
        chk("timeout exc", 32'(cpu_exc_out), 32'd4);
        chk("timeout rdata", cpu_rdata, 32'h0);
`else
        chk("no-timeout stall cycles", 32'(n), 32'd20);
        chk("no-timeout exc", 32'(cpu_exc_out), 32'd0);
        chk("no-timeout rdata", cpu_rdata, 32'hCAFEF00D);
`endif
        @(posedge clk); #1 drive(NOP, 32'h0, 32'h0, 4'h0, 5'd0); dev_ready = 2'b00;

`ifdef BRIDGE_TIMEOUT_EN
        // Ready arriving on the last counted WAIT cycle wins over the timeout.
        @(posedge clk); #1 drive(LW, 32'h7F00, 32'h0, 4'h0, 5'd0);
        @(negedge clk);
        n = 0;
        while (cpu_stall === 1'b1 && n < 40) begin
            n++;
            if (n == 16) dev_ready = 2'b01;
            @(negedge clk);
        end
        chk("ready-wins stall cycles", 32'(n), 32'd16);
        chk("ready-wins exc", 32'(cpu_exc_out), 32'd0);
        chk("ready-wins rdata", cpu_rdata, 32'hCAFEF00D);
        @(posedge clk); #1 drive(NOP, 32'h0, 32'h0, 4'h0, 5'd0); dev_ready = 2'b00;
`endif

        // Reset during the second WAIT cycle abandons the write.
        commits = 0;
        @(posedge clk); #1 drive(SW, 32'h7F04, 32'h99, 4'hF, 5'd0);
        @(posedge clk);                  // -> WAIT1
        @(posedge clk); #1;              // now in WAIT2
        chk("rst wait2 dev_sel", 32'(dev_sel), 32'h1);
        reset = 1'b1; drive(NOP, 32'h0, 32'h0, 4'h0, 5'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("rst dev_sel", 32'(dev_sel), 32'h0);
        chk("rst dev_we", 32'(dev_we), 32'h0);
        chk("rst stall", 32'(cpu_stall), 32'h0);
        @(posedge clk); #1 dev_ready = 2'b01;
        @(posedge clk); #1 dev_ready = 2'b00;
        @(negedge clk);
        chk("rst no commit", 32'(commits), 32'h0);
        chk("rst still idle", 32'(dev_sel), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
